// File: rtl/apu_frame_encoder.sv
// Host-side serialiser for the APU register link: each accepted write leaves as a
// low-nibble frame then a high-nibble frame on sdo, timed by a free-running sck.
module apu_frame_encoder #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       sck,
  output logic       sdo,
  output logic       busy
);

  typedef enum logic [1:0] {SYNC, IDLE, LO, HI} state_e;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             sdo_q, sdo_d;
  logic [3:0]       bit_q, bit_d;
  logic             buf_full_q, buf_full_d;
  logic [9:0]       buf_q;
  logic [9:0]       shift_q;

  logic       div_term;
  logic       fall;
  logic       accept;
  logic       transfer;
  logic [3:0] bit_nxt;
  logic [9:0] frame_lo;
  logic [9:0] frame_hi;

  // wr = {addr[1:0], data[7:0]}; returned vector is transmitted bit0 first.
  function automatic logic [9:0] frame_bits(input logic [9:0] wr, input logic phase);
    logic [3:0] nib;
    nib = phase ? wr[7:4] : wr[3:0];
    return {1'b1, 1'b0, wr[9], wr[8], phase, nib, 1'b0};
  endfunction

  assign div_term = (div_q == DIV_LAST);
  assign fall     = div_term && sck_q;
  assign accept   = wr_valid && !buf_full_q;
  assign bit_nxt  = bit_q + 4'd1;
  assign frame_lo = frame_bits(shift_q, 1'b0);
  assign frame_hi = frame_bits(shift_q, 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      div_q      <= '0;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b1;
      bit_q      <= 4'd0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      bit_q      <= bit_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Payload registers carry no reset; buf_full_q qualifies buf_q.
  always_ff @(posedge clk) begin
    if (accept)   buf_q   <= {wr_addr, wr_data};
    if (transfer) shift_q <= buf_q;
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sdo_d    = sdo_q;
    transfer = 1'b0;
    div_d    = div_term ? '0 : div_q + 1'b1;
    sck_d    = div_term ? ~sck_q : sck_q;
    if (fall) begin
      case (state_q)
        SYNC: begin
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (buf_full_q) begin
              transfer = 1'b1;
              state_d  = LO;
              sdo_d    = 1'b0;
            end else begin
              state_d = IDLE;
              sdo_d   = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
          end
        end
        IDLE: begin
          if (buf_full_q) begin
            transfer = 1'b1;
            state_d  = LO;
            bit_d    = 4'd0;
            sdo_d    = 1'b0;
          end
        end
        LO: begin
          if (bit_q == 4'd9) begin
            state_d = HI;
            bit_d   = 4'd0;
            sdo_d   = 1'b0;
          end else begin
            bit_d = bit_nxt;
            sdo_d = frame_lo[bit_nxt];
          end
        end
        HI: begin
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (buf_full_q) begin
              transfer = 1'b1;
              state_d  = LO;
              sdo_d    = 1'b0;
            end else begin
              state_d = IDLE;
              sdo_d   = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
            sdo_d = frame_hi[bit_nxt];
          end
        end
        default: state_d = SYNC;
      endcase
    end
    buf_full_d = transfer ? 1'b0 : (accept ? 1'b1 : buf_full_q);
  end

  always_comb begin
    wr_ready = !buf_full_q;
    busy     = (state_q != IDLE) || buf_full_q;
    sck      = sck_q;
    sdo      = sdo_q;
  end

endmodule

// File: tb/tb_apu_frame_encoder.sv
// Directed bench for apu_frame_encoder with CLK_DIV=2; a receive-side model
// decodes sdo on rising sck and rebuilds the APU register file.
module tb_apu_frame_encoder;

  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ready;
  logic       sck;
  logic       sdo;
  logic       busy;

  int errors = 0;
  int checks = 0;

  apu_frame_encoder #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sck      (sck),
    .sdo      (sdo),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Receive-side model: start on a sampled 0, collect 10 bits, accept only
  // frames with start=0, reserved=0, stop=1; low frame parks its nibble.
  logic [9:0] sh = '0;
  logic [9:0] fcur;
  int         nb = 0;
  logic       in_frame = 1'b0;
  int         fstart = 0;
  int         rise_cnt = 0;
  int         rejects = 0;
  logic       pend_v = 1'b0;
  logic [1:0] pend_a = 2'd0;
  logic [3:0] pend_n = 4'd0;
  logic [7:0] dregs [4] = '{default: 8'h5A};
  logic [9:0] fr_val [$];
  int         fr_start [$];

  assign fcur = {sdo, sh[8:0]};

  always @(posedge sck) begin
    rise_cnt <= rise_cnt + 1;
    if (!in_frame) begin
      if (sdo == 1'b0) begin
        in_frame <= 1'b1;
        sh       <= '0;
        nb       <= 1;
        fstart   <= rise_cnt + 1;
      end
    end else begin
      sh[nb] <= sdo;
      if (nb == 9) begin
        in_frame <= 1'b0;
        if (fcur[9] == 1'b1 && fcur[8] == 1'b0) begin
          fr_val.push_back(fcur);
          fr_start.push_back(fstart);
          if (fcur[5] == 1'b0) begin
            pend_v <= 1'b1;
            pend_a <= fcur[7:6];
            pend_n <= fcur[4:1];
          end else begin
            if (pend_v && pend_a == fcur[7:6]) dregs[fcur[7:6]] <= {fcur[4:1], pend_n};
            pend_v <= 1'b0;
          end
        end else begin
          rejects <= rejects + 1;
          pend_v  <= 1'b0;
        end
      end else begin
        nb <= nb + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (fr_val.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_frames", 32'(fr_val.size() >= n), 32'd1);
  endtask

  // Leaves wr_valid high; returns on the negedge after the accepting edge.
  task automatic push(input logic [1:0] a, input logic [7:0] d);
    int c = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("push_accept", 32'(c < 200), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int f0;
    int n;
    int c;
    int target;
    int r_rel;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck", sck, 0);
    check("rst_sdo", sdo, 1);
    check("rst_rdy", wr_ready, 1);
    check("rst_busy", busy, 1);

    // SYNC then idle: sck period 4, sdo high, busy drops at cycle 40
    rst_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      check("idle_sck", sck, (k / 2) % 2);
      check("idle_sdo", sdo, 1);
      check("idle_rdy", wr_ready, 1);
      check("idle_busy", busy, 32'(k < 40));
    end

    // Single write reg2=A5 from IDLE
    f0 = fr_val.size();
    wr_addr  = 2'd2;
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    @(negedge clk);
    check("acc_rdy", wr_ready, 0);
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_start_sdo", sdo, 1);
    @(negedge clk);
    check("start_sdo", sdo, 0);
    check("start_rdy", wr_ready, 1);
    wait_frames(f0 + 2, 300);
    check("a5_lo_frame", fr_val[f0], 10'h28A);
    check("a5_hi_frame", fr_val[f0 + 1], 10'h2B4);
    check("a5_reg2", dregs[2], 8'hA5);
    check("a5_reg0", dregs[0], 8'h5A);
    check("a5_reg1", dregs[1], 8'h5A);
    check("a5_reg3", dregs[3], 8'h5A);
    repeat (4) @(negedge clk);
    check("post_busy", busy, 0);
    check("post_sdo", sdo, 1);

    // Four writes, wr_valid held throughout
    f0 = fr_val.size();
    push(2'd0, 8'h00);
    push(2'd1, 8'hFF);
    push(2'd2, 8'h3C);
    push(2'd3, 8'hC3);
    wr_valid = 1'b0;
    wait_frames(f0 + 8, 800);
    for (int i = 1; i < 8; i++) check("contig", fr_start[f0 + i] - fr_start[f0], 10 * i);
    check("burst_reg0", dregs[0], 8'h00);
    check("burst_reg1", dregs[1], 8'hFF);
    check("burst_reg2", dregs[2], 8'h3C);
    check("burst_reg3", dregs[3], 8'hC3);

    // Second write during first LO: buffer stays full for one full write
    f0 = fr_val.size();
    push(2'd1, 8'h12);
    push(2'd3, 8'h34);
    wr_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("hold_rdy_low", n, 79);
    wait_frames(f0 + 4, 400);
    check("first_lo_frame", fr_val[f0], 10'h244);
    check("second_lo_frame", fr_val[f0 + 2], 10'h2C8);
    check("b2b_gap", fr_start[f0 + 2] - fr_start[f0], 20);
    check("b2b_reg1", dregs[1], 8'h12);
    check("b2b_reg3", dregs[3], 8'h34);

    // Reset at HI bit4 with a second write buffered
    f0 = fr_val.size();
    push(2'd0, 8'h99);
    push(2'd1, 8'h11);
    wr_valid = 1'b0;
    wait_frames(f0 + 1, 300);
    target = fr_start[f0] + 14;
    c = 0;
    while (rise_cnt < target && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("reach_hi_bit4", 32'(c < 300), 32'd1);
    check("pre_rst_sck", sck, 1);
    check("pre_rst_rdy", wr_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_sck", sck, 0);
    check("async_sdo", sdo, 1);
    check("async_rdy", wr_ready, 1);
    check("async_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);

    // Write presented during SYNC is taken at once and starts at fall event 10
    wr_addr  = 2'd0;
    wr_data  = 8'h66;
    wr_valid = 1'b1;
    r_rel    = rise_cnt;
    rst_n    = 1'b1;
    @(negedge clk);
    check("sync_acc_rdy", wr_ready, 0);
    wr_valid = 1'b0;
    repeat (38) @(negedge clk);
    check("sync_k39_sdo", sdo, 1);
    check("sync_k39_busy", busy, 1);
    check("trunc_reg0_kept", dregs[0], 8'h00);
    check("trunc_rejected", rejects, 1);
    @(negedge clk);
    check("sync_k40_sdo", sdo, 0);
    wait_frames(f0 + 3, 400);
    check("resync_start", fr_start[f0 + 1], r_rel + 11);
    check("resync_lo_frame", fr_val[f0 + 1], 10'h20C);
    check("resync_reg0", dregs[0], 8'h66);
    repeat (100) @(negedge clk);
    check("discarded_frames", fr_val.size(), f0 + 3);
    check("discarded_reg1", dregs[1], 8'h12);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
